// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812B pixel path: FSM state encoding,
// GRB byte positions inside a pixel word and pixel/byte widths.
package ws2812_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        OFFER   = 2'd1,
        GAP     = 2'd2
    } state_t;

    localparam int PIX_W  = 24;
    localparam int BYTE_W = 8;

    // Byte lane offsets inside the 24-bit GRB pixel {G, R, B}
    localparam int G_POS = 16;
    localparam int R_POS = 8;
    localparam int B_POS = 0;

    // Channel scaling used when the brightness limit is built in
    function automatic logic [BYTE_W-1:0] scale_byte(input logic [BYTE_W-1:0] b,
                                                     input int shift);
        return b >> shift;
    endfunction

endpackage

// File: rtl/ws2812_gap_timer.sv
// Loadable down-counter that times the WS2812 latch/reset gap.
// A start pulse loads GAP_CYCLES-1; done is high during the last gap
// cycle, so the owner sees it on the GAP_CYCLES-th edge after start.
module ws2812_gap_timer #(
    parameter int GAP_CYCLES = 1500
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done
);

    localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(GAP_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          busy;

    // Load on start, count down to zero, then go idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            cnt  <= LOAD_VAL;
            busy <= 1'b1;
        end else if (busy) begin
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign done = busy && (cnt == '0);

endmodule

// File: rtl/ws2812_pixel_feeder.sv
// Packs three consecutive random bytes into a GRB pixel, offers it to the
// WS2812B serializer over valid/ready, counts NUM_LEDS pixels per frame and
// then waits out the latch gap. Optional feature macro:
// WS2812_BRIGHTNESS_LIMIT_EN (each byte stored as rnd_in >> BRIGHT_SHIFT).
module ws2812_pixel_feeder
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS     = 8,
    parameter int GAP_CYCLES   = 1500,
    parameter int BRIGHT_SHIFT = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    rnd_in,
    output logic [23:0]                   pix_data,
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic [$clog2(NUM_LEDS+1)-1:0] led_idx,
    output logic                          frame_done
);

    localparam int IW = $clog2(NUM_LEDS + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_LEDS - 1);

`ifdef WS2812_BRIGHTNESS_LIMIT_EN
    localparam int APPLIED_SHIFT = BRIGHT_SHIFT;
`else
    localparam int APPLIED_SHIFT = 0;
`endif

    state_t            state;
    logic [1:0]        byte_cnt;
    logic [BYTE_W-1:0] sample;
    logic              gap_start;
    logic              gap_done;

    assign sample    = scale_byte(rnd_in, APPLIED_SHIFT);
    assign gap_start = (state == OFFER) && pix_valid && pix_ready && (led_idx == LAST_IDX);

    ws2812_gap_timer #(
        .GAP_CYCLES(GAP_CYCLES)
    ) u_gap_timer (
        .clk  (clk),
        .rst  (rst),
        .start(gap_start),
        .done (gap_done)
    );

    // Collector / handshake / frame FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= COLLECT;
            byte_cnt   <= '0;
            pix_data   <= '0;
            pix_valid  <= 1'b0;
            led_idx    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                COLLECT: begin
                    case (byte_cnt)
                        2'd0: begin
                            pix_data[G_POS +: BYTE_W] <= sample;
                            byte_cnt                  <= 2'd1;
                        end
                        2'd1: begin
                            pix_data[R_POS +: BYTE_W] <= sample;
                            byte_cnt                  <= 2'd2;
                        end
                        default: begin
                            pix_data[B_POS +: BYTE_W] <= sample;
                            byte_cnt                  <= 2'd0;
                            pix_valid                 <= 1'b1;
                            state                     <= OFFER;
                        end
                    endcase
                end
                OFFER: begin
                    if (pix_valid && pix_ready) begin
                        pix_valid <= 1'b0;
                        if (led_idx == LAST_IDX) begin
                            led_idx <= '0;
                            state   <= GAP;
                        end else begin
                            led_idx <= led_idx + 1'b1;
                            state   <= COLLECT;
                        end
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        frame_done <= 1'b1;
                        state      <= COLLECT;
                    end
                end
                default: begin
                    state     <= COLLECT;
                    byte_cnt  <= '0;
                    pix_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_pixel_feeder.sv
// Scoreboard bench for ws2812_pixel_feeder (NUM_LEDS=3, GAP_CYCLES=5).
// Builds with or without WS2812_BRIGHTNESS_LIMIT_EN.
module tb_ws2812_pixel_feeder;

    localparam int NUM_LEDS     = 3;
    localparam int GAP_CYCLES   = 5;
    localparam int BRIGHT_SHIFT = 2;
    localparam int IW           = $clog2(NUM_LEDS + 1);

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic [7:0]    rnd_in    = 8'h00;
    logic          pix_ready = 1'b0;
    logic [23:0]   pix_data;
    logic          pix_valid;
    logic [IW-1:0] led_idx;
    logic          frame_done;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [23:0]   data;
        logic [IW-1:0] idx;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    ws2812_pixel_feeder #(
        .NUM_LEDS    (NUM_LEDS),
        .GAP_CYCLES  (GAP_CYCLES),
        .BRIGHT_SHIFT(BRIGHT_SHIFT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rnd_in    (rnd_in),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .led_idx   (led_idx),
        .frame_done(frame_done)
    );

    function automatic logic [7:0] stored(input logic [7:0] b);
`ifdef WS2812_BRIGHTNESS_LIMIT_EN
        return b >> BRIGHT_SHIFT;
`else
        return b;
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b,
                            input logic [IW-1:0] idx);
        exp_t e;
        e.data = {stored(g), stored(r), stored(b)};
        e.idx  = idx;
        exp_q.push_back(e);
    endtask

    // Drives G, R, B on three consecutive edges; returns just after the third
    task automatic collect_pixel(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b,
                                 input logic [IW-1:0] idx);
        rnd_in = g;
        tick;
        rnd_in = r;
        tick;
        rnd_in = b;
        push_exp(g, r, b, idx);
        tick;
        rnd_in = 8'($urandom);
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        exp_q.delete();
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rnd_in    = 8'($urandom);
            pix_ready = i[0];
            tick;
            checks++;
            if (pix_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_valid cyc%0d got=%b want=0", i, pix_valid);
            end
            checks++;
            if (pix_data !== 24'h0) begin
                failures++;
                $display("FAIL reset_data cyc%0d got=%h want=000000", i, pix_data);
            end
            checks++;
            if (led_idx !== '0) begin
                failures++;
                $display("FAIL reset_idx cyc%0d got=%0d want=0", i, led_idx);
            end
            checks++;
            if (frame_done !== 1'b0) begin
                failures++;
                $display("FAIL reset_frame_done cyc%0d got=%b want=0", i, frame_done);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        exp_t e;
        logic [7:0] bytes [3];
        bytes[0] = 8'h11;
        bytes[1] = 8'h22;
        bytes[2] = 8'h33;
        pix_ready = 1'b1;
        push_exp(bytes[0], bytes[1], bytes[2], '0);
        for (int i = 0; i < 3; i++) begin
            rnd_in = bytes[i];
            tick;
            if (i < 2) begin
                checks++;
                if (pix_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_early_valid edge%0d got=%b want=0", i + 1, pix_valid);
                end
            end
        end
        rnd_in = 8'($urandom);
        checks++;
        if (pix_valid !== 1'b1) begin
            failures++;
            $display("FAIL basic_valid got=%b want=1", pix_valid);
        end
        e = exp_q.pop_front();
        checks++;
        if (pix_data !== e.data) begin
            failures++;
            $display("FAIL basic_data got=%h want=%h", pix_data, e.data);
        end
        checks++;
        if (led_idx !== e.idx) begin
            failures++;
            $display("FAIL basic_idx got=%0d want=%0d", led_idx, e.idx);
        end
        tick;
        checks++;
        if (pix_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_valid_one_cycle got=%b want=0", pix_valid);
        end
        checks++;
        if (led_idx !== IW'(1)) begin
            failures++;
            $display("FAIL basic_idx_advance got=%0d want=1", led_idx);
        end
    endtask

    task automatic test_hold;
        exp_t e;
        pix_ready = 1'b0;
        collect_pixel(8'hA5, 8'h5A, 8'hC3, IW'(1));
        checks++;
        if (pix_valid !== 1'b1) begin
            failures++;
            $display("FAIL hold_valid got=%b want=1", pix_valid);
        end
        e = exp_q.pop_front();
        checks++;
        if (pix_data !== e.data || led_idx !== e.idx) begin
            failures++;
            $display("FAIL hold_first got=%h/%0d want=%h/%0d", pix_data, led_idx, e.data, e.idx);
        end
        for (int i = 0; i < 10; i++) begin
            rnd_in = 8'($urandom);
            tick;
            checks++;
            if (pix_valid !== 1'b1 || pix_data !== e.data || led_idx !== e.idx) begin
                failures++;
                $display("FAIL hold_stable cyc%0d got=%b/%h/%0d want=1/%h/%0d",
                         i, pix_valid, pix_data, led_idx, e.data, e.idx);
            end
        end
        pix_ready = 1'b1;
        tick;
        checks++;
        if (pix_valid !== 1'b0 || led_idx !== IW'(2)) begin
            failures++;
            $display("FAIL hold_accept got=%b/%0d want=0/2", pix_valid, led_idx);
        end
    endtask

    task automatic test_frame;
        exp_t e;
        apply_reset;
        pix_ready = 1'b1;
        for (int i = 0; i < NUM_LEDS; i++) begin
            collect_pixel(8'($urandom), 8'($urandom), 8'($urandom), IW'(i));
            checks++;
            if (pix_valid !== 1'b1) begin
                failures++;
                $display("FAIL frame_valid px%0d got=%b want=1", i, pix_valid);
            end
            e = exp_q.pop_front();
            checks++;
            if (pix_data !== e.data || led_idx !== e.idx) begin
                failures++;
                $display("FAIL frame_pixel px%0d got=%h/%0d want=%h/%0d",
                         i, pix_data, led_idx, e.data, e.idx);
            end
            tick;
        end
        checks++;
        if (led_idx !== '0) begin
            failures++;
            $display("FAIL frame_idx_wrap got=%0d want=0", led_idx);
        end
        for (int i = 0; i < GAP_CYCLES; i++) begin
            checks++;
            if (pix_valid !== 1'b0 || frame_done !== 1'b0) begin
                failures++;
                $display("FAIL frame_gap cyc%0d got=%b/%b want=0/0", i, pix_valid, frame_done);
            end
            tick;
        end
        checks++;
        if (frame_done !== 1'b1 || pix_valid !== 1'b0 || led_idx !== '0) begin
            failures++;
            $display("FAIL frame_done_pulse got=%b/%b/%0d want=1/0/0", frame_done, pix_valid, led_idx);
        end
        collect_pixel(8'h01, 8'h02, 8'h03, '0);
        e = exp_q.pop_front();
        checks++;
        if (frame_done !== 1'b0 || pix_valid !== 1'b1 || pix_data !== e.data || led_idx !== e.idx) begin
            failures++;
            $display("FAIL frame_restart got=%b/%b/%h/%0d want=0/1/%h/%0d",
                     frame_done, pix_valid, pix_data, led_idx, e.data, e.idx);
        end
        tick;
    endtask

    task automatic test_reset_mid;
        exp_t e;
        apply_reset;
        pix_ready = 1'b1;
        collect_pixel(8'h10, 8'h20, 8'h30, '0);
        e = exp_q.pop_front();
        tick;
        pix_ready = 1'b0;
        collect_pixel(8'h44, 8'h55, 8'h66, IW'(1));
        e = exp_q.pop_front();
        checks++;
        if (pix_valid !== 1'b1 || pix_data !== e.data || led_idx !== e.idx) begin
            failures++;
            $display("FAIL midrst_offer got=%b/%h/%0d want=1/%h/%0d",
                     pix_valid, pix_data, led_idx, e.data, e.idx);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (pix_valid !== 1'b0 || pix_data !== 24'h0 || led_idx !== '0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async got=%b/%h/%0d/%b want=0/000000/0/0",
                     pix_valid, pix_data, led_idx, frame_done);
        end
        exp_q.delete();
        tick;
        tick;
        rst = 1'b0;
        pix_ready = 1'b1;
        collect_pixel(8'h3C, 8'h96, 8'h0F, '0);
        e = exp_q.pop_front();
        checks++;
        if (pix_valid !== 1'b1 || pix_data !== e.data || led_idx !== e.idx) begin
            failures++;
            $display("FAIL midrst_restart got=%b/%h/%0d want=1/%h/%0d",
                     pix_valid, pix_data, led_idx, e.data, e.idx);
        end
        tick;
    endtask

    task automatic test_brightness;
        exp_t e;
        logic [23:0] want_const;
`ifdef WS2812_BRIGHTNESS_LIMIT_EN
        want_const = 24'h3F2001;
`else
        want_const = 24'hFF8004;
`endif
        pix_ready = 1'b1;
        collect_pixel(8'hFF, 8'h80, 8'h04, IW'(1));
        e = exp_q.pop_front();
        checks++;
        if (pix_valid !== 1'b1 || pix_data !== e.data || led_idx !== e.idx) begin
            failures++;
            $display("FAIL bright_model got=%b/%h/%0d want=1/%h/%0d",
                     pix_valid, pix_data, led_idx, e.data, e.idx);
        end
        checks++;
        if (pix_data !== want_const) begin
            failures++;
            $display("FAIL bright_const got=%h want=%h", pix_data, want_const);
        end
        tick;
        checks++;
        if (pix_valid !== 1'b0) begin
            failures++;
            $display("FAIL bright_accept got=%b want=0", pix_valid);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_hold;
        test_frame;
        test_reset_mid;
        test_brightness;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
